camera_capture_mf: RTL and testbench

- Parametrised successor to the OV-series pixel capture front end, sitting between the camera DVP pins and the DDR write arbiter.
- Packs the 8-bit byte stream into OUT_W-bit words and realigns packing at every line start.
- Generates a write word address inside a ring of NUM_FRAMES frame buffers and validates line/frame geometry.
- Drops malformed frames without advancing the buffer ring, and issues the HDR exposure-change pulse at a configurable row.

---
 rtl/camera_capture_mf.sv | 141 ++++++++++++++
 tb/tb_camera_capture_mf.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_mf.sv
// DVP byte-stream capture: packs camera bytes into OUT_W-bit words, addresses them
// inside a ring of frame buffers, and drops malformed frames without advancing the ring.
module camera_capture_mf #(
   parameter int OUT_W      = 128,
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int BPP        = 2,
   parameter int NUM_FRAMES = 6,
   parameter int EXP_ROW    = 480,
   parameter int ADDR_W     = 25,
   localparam int FI_W      = $clog2(NUM_FRAMES)
) (
   input  logic              p_clk,
   input  logic              rst_n,
   input  logic [7:0]        data,
   input  logic              href,
   input  logic              vsync,
   input  logic              take_pic,
   input  logic              hdr_en,
   output logic [OUT_W-1:0]  p_data,
   output logic              data_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [FI_W-1:0]   frame_idx,
   output logic              frame_done,
   output logic              frame_err,
   output logic              change_exp
);
   // state   | meaning
   // IDLE    | waiting for vsync falling edge
   // CAPTURE | inside a frame, packing bytes and tracking geometry

   localparam int BPW         = OUT_W / 8;
   localparam int LINE_BYTES  = IMG_W * BPP;
   localparam int LINE_WORDS  = LINE_BYTES / BPW;
   localparam int FRAME_WORDS = IMG_H * LINE_WORDS;
   localparam int BC_W        = $clog2(LINE_BYTES + 2);
   localparam int ROW_W       = $clog2(IMG_H + 2);
   localparam int LANE_W      = $clog2(BPW + 1);

   if ((OUT_W % 8) != 0 || (LINE_BYTES % BPW) != 0 || NUM_FRAMES < 2) begin : g_bad_geometry
      $error("camera_capture_mf: line length must be a whole number of output words");
   end

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t            state;
   logic              q_href, q_vsync, err;
   logic [BC_W-1:0]   byte_cnt;
   logic [ROW_W-1:0]  row;
   logic [LANE_W-1:0] lane;

   logic              frame_start, frame_end, line_end, in_rows, short_line, err_nxt, clean;
   logic [ROW_W-1:0]  row_nxt;
   logic [FI_W-1:0]   idx_inc;
   logic [ADDR_W-1:0] frame_base, line_base;

   always_comb begin
      frame_start = !vsync && q_vsync;
      frame_end   = vsync && !q_vsync;
      // vsync rising while href is still high cuts the current line short
      line_end    = (!href && q_href) || (frame_end && href);
      in_rows     = row < ROW_W'(IMG_H);
      short_line  = line_end && in_rows &&
                    ((byte_cnt != BC_W'(LINE_BYTES)) || (frame_end && href));
      err_nxt     = err || short_line || (href && !in_rows);
      row_nxt     = (line_end && in_rows) ? row + ROW_W'(1) : row;
      clean       = !err_nxt && (row_nxt == ROW_W'(IMG_H));
      idx_inc     = (frame_idx == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + FI_W'(1);
      frame_base  = ADDR_W'(frame_idx) * ADDR_W'(FRAME_WORDS);
      line_base   = frame_base + ADDR_W'(row_nxt) * ADDR_W'(LINE_WORDS);
   end

   always_ff @(posedge p_clk) begin
      if (!rst_n || take_pic) begin
         state      <= IDLE;
         q_href     <= 1'b0;
         q_vsync    <= 1'b1;
         byte_cnt   <= '0;
         row        <= '0;
         lane       <= '0;
         err        <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         change_exp <= 1'b0;
         if (!rst_n) begin
            frame_idx <= '0;
            wr_addr   <= '0;
         end else begin
            wr_addr   <= frame_base;
         end
      end else begin
         q_href     <= href;
         q_vsync    <= vsync;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         change_exp <= 1'b0;
         if (state == IDLE) begin
            if (frame_start) begin
               state    <= CAPTURE;
               row      <= '0;
               byte_cnt <= '0;
               lane     <= '0;
               err      <= 1'b0;
               wr_addr  <= frame_base;
            end
         end else begin
            err <= err_nxt;
            if (data_valid) wr_addr <= wr_addr + ADDR_W'(1);
            if (line_end) begin
               // partial word is dropped; next line always starts on a word boundary
               row      <= row_nxt;
               byte_cnt <= '0;
               lane     <= '0;
               if (in_rows) wr_addr <= line_base;
               if (in_rows && row_nxt == ROW_W'(EXP_ROW) && hdr_en) change_exp <= 1'b1;
            end else if (href && in_rows && byte_cnt != BC_W'(LINE_BYTES + 1)) begin
               byte_cnt <= byte_cnt + BC_W'(1);
               if (byte_cnt < BC_W'(LINE_BYTES)) begin
                  p_data[8*lane +: 8] <= data;
                  if (lane == LANE_W'(BPW - 1)) begin
                     lane       <= '0;
                     data_valid <= 1'b1;
                  end else begin
                     lane <= lane + LANE_W'(1);
                  end
               end
            end
            if (frame_end) begin
               state      <= IDLE;
               frame_done <= 1'b1;
               frame_err  <= !clean;
               if (clean) frame_idx <= idx_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_camera_capture_mf.sv
// Bench for camera_capture_mf: frames are described as line lengths; expected strobes,
// frame results and exposure pulses are derived per line/frame and compared every cycle.
module tb_camera_capture_mf;
   localparam int OUT_W = 32, IMG_W = 4, IMG_H = 2, BPP = 2, NF = 3, EXP_ROW = 1, ADDR_W = 25;
   localparam int BPW = OUT_W / 8, LB = IMG_W * BPP, LW = LB / BPW, FW = IMG_H * LW;

   logic              p_clk = 1'b0;
   logic              rst_n, href, vsync, take_pic, hdr_en;
   logic [7:0]        data;
   logic [OUT_W-1:0]  p_data;
   logic              data_valid, frame_done, frame_err, change_exp;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        frame_idx;

   camera_capture_mf #(
      .OUT_W(OUT_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .BPP(BPP),
      .NUM_FRAMES(NF), .EXP_ROW(EXP_ROW), .ADDR_W(ADDR_W)
   ) dut (
      .p_clk(p_clk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync),
      .take_pic(take_pic), .hdr_en(hdr_en), .p_data(p_data), .data_valid(data_valid),
      .wr_addr(wr_addr), .frame_idx(frame_idx), .frame_done(frame_done),
      .frame_err(frame_err), .change_exp(change_exp)
   );

   always #5 p_clk = ~p_clk;

   typedef struct { int cyc; logic [OUT_W-1:0] data; logic [ADDR_W-1:0] addr; } strobe_t;
   typedef struct { int cyc; bit done; bit err; int idx; } fev_t;

   int        cyc = 0;
   int        n_checks = 0, n_err = 0;
   bit        chk_en = 1'b0;
   strobe_t   sq[$], seen[$];
   fev_t      fq[$];
   int        cq[$];
   int        line_len[$];
   int        exp_idx = 0, m_idx = 0, cexp_cnt = 0, done_cnt = 0;
   bit        last_err;
   logic [7:0] byte_ctr;
   logic [OUT_W-1:0] w_acc;
   strobe_t   st;
   fev_t      fe;

   always @(posedge p_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge p_clk) begin
      if (chk_en) begin
         if (sq.size() != 0 && sq[0].cyc == cyc) begin
            st = sq.pop_front();
            chk("data_valid", data_valid, 1);
            chk("p_data", p_data, st.data);
            chk("wr_addr", wr_addr, st.addr);
         end else begin
            chk("data_valid_quiet", data_valid, 0);
         end
         if (data_valid === 1'b1) begin
            st.cyc = cyc; st.data = p_data; st.addr = wr_addr;
            seen.push_back(st);
         end
         if (cq.size() != 0 && cq[0] == cyc) begin
            void'(cq.pop_front());
            chk("change_exp", change_exp, 1);
         end else begin
            chk("change_exp_quiet", change_exp, 0);
         end
         if (change_exp === 1'b1) cexp_cnt++;
         if (fq.size() != 0 && fq[0].cyc == cyc) begin
            fe = fq.pop_front();
            chk("frame_done", frame_done, fe.done);
            chk("frame_err", frame_err, fe.err);
            exp_idx = fe.idx;
         end else begin
            chk("frame_done_quiet", frame_done, 0);
            chk("frame_err_quiet", frame_err, 0);
         end
         if (frame_done === 1'b1) begin
            done_cnt++;
            last_err = frame_err;
         end
         chk("frame_idx", frame_idx, exp_idx);
      end
   end

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   task automatic set_lines(input int n, input int first, input int rest);
      line_len.delete();
      for (int i = 0; i < n; i++) line_len.push_back(i == 0 ? first : rest);
   endtask

   // drives one byte; in-geometry bytes contribute to the expected word stream
   task automatic send_byte(input logic [7:0] b, input int k, input int row, input int base);
      strobe_t s;
      data = b;
      href = 1'b1;
      if (row < IMG_H && k < LB) begin
         w_acc[8*(k%BPW) +: 8] = b;
         if (k % BPW == BPW - 1) begin
            s.cyc = cyc + 1; s.data = w_acc; s.addr = ADDR_W'(base + row*LW + k/BPW);
            sq.push_back(s);
         end
      end
      tick();
   endtask

   task automatic push_frame_end(input int row, input bit ferr);
      fev_t e;
      bit clean;
      clean = !ferr && row == IMG_H;
      e.cyc = cyc + 1; e.done = 1'b1; e.err = !clean;
      e.idx = clean ? (m_idx + 1) % NF : m_idx;
      fq.push_back(e);
      m_idx = e.idx;
   endtask

   task automatic run_frame(input bit hdr, input bit inc, input bit cut_last);
      int row, base, nl;
      bit ferr, cut;
      row = 0; ferr = 1'b0; base = m_idx * FW; nl = line_len.size();
      hdr_en = hdr;
      vsync = 1'b0;
      tick();
      repeat ($urandom_range(0, 2)) tick();
      for (int l = 0; l < nl; l++) begin
         cut = cut_last && (l == nl - 1);
         for (int k = 0; k < line_len[l]; k++) begin
            send_byte(inc ? byte_ctr : 8'($urandom), k, row, base);
            byte_ctr = byte_ctr + 8'd1;
         end
         if (row < IMG_H) begin
            if (line_len[l] != LB || cut) ferr = 1'b1;
            if (row + 1 == EXP_ROW && hdr) cq.push_back(cyc + 1);
            row++;
         end else begin
            ferr = 1'b1;
         end
         if (cut) begin
            data = 8'($urandom);
            vsync = 1'b1;
            push_frame_end(row, ferr);
            tick();
            href = 1'b0;
            tick();
         end else begin
            href = 1'b0;
            tick();
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      if (!cut_last) begin
         vsync = 1'b1;
         push_frame_end(row, ferr);
         tick();
      end
      repeat ($urandom_range(2, 3)) tick();
   endtask

   task automatic do_reset();
      fev_t e;
      rst_n = 1'b0;
      e.cyc = cyc + 1; e.done = 1'b0; e.err = 1'b0; e.idx = 0;
      fq.push_back(e);
      m_idx = 0;
      tick();
      chk("rst_frame_idx", frame_idx, 0);
      chk("rst_p_data", p_data, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_change_exp", change_exp, 0);
      href = 1'b0;
      vsync = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [31:0] t1_words [4];
      t1_words[0] = 32'h03020100; t1_words[1] = 32'h07060504;
      t1_words[2] = 32'h0B0A0908; t1_words[3] = 32'h0F0E0D0C;
      rst_n = 1'b0; take_pic = 1'b0; hdr_en = 1'b0; vsync = 1'b1; href = 1'b0; data = '0;
      byte_ctr = '0; w_acc = '0;
      chk_en = 1'b1;
      do_reset();

      // 1: clean frame with incrementing bytes
      seen.delete(); byte_ctr = 8'h00;
      set_lines(2, LB, LB);
      run_frame(1'b0, 1'b1, 1'b0);
      chk("t1_strobe_count", seen.size(), 4);
      if (seen.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t1_word", seen[i].data, t1_words[i]);
            chk("t1_addr", seen[i].addr, i);
         end
      end
      chk("t1_frame_err", last_err, 0);
      chk("t1_frame_idx", frame_idx, 1);

      // 2: ring wraps 1 -> 2 -> 0 -> 1
      for (int i = 0; i < 3; i++) begin
         seen.delete();
         run_frame(1'b0, 1'b0, 1'b0);
         chk("t2_strobe_count", seen.size(), 4);
         if (seen.size() == 4) chk("t2_first_addr", seen[0].addr, (i == 0) ? 4 : (i == 1) ? 8 : 0);
         chk("t2_frame_idx", frame_idx, (i == 0) ? 2 : (i == 1) ? 0 : 1);
      end

      // 3: short first line
      do_reset();
      seen.delete();
      set_lines(2, 6, LB);
      run_frame(1'b0, 1'b0, 1'b0);
      chk("t3_strobe_count", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("t3_addr0", seen[0].addr, 0);
         chk("t3_addr1", seen[1].addr, 2);
         chk("t3_addr2", seen[2].addr, 3);
      end
      chk("t3_frame_err", last_err, 1);
      chk("t3_frame_idx", frame_idx, 0);

      // 4: one line too many
      seen.delete();
      set_lines(3, LB, LB);
      run_frame(1'b0, 1'b0, 1'b0);
      chk("t4_strobe_count", seen.size(), 4);
      chk("t4_wr_addr_frozen", wr_addr, 4);
      chk("t4_frame_err", last_err, 1);
      chk("t4_frame_idx", frame_idx, 0);

      // 5: exposure pulse with and without hdr_en
      c0 = cexp_cnt;
      set_lines(2, LB, LB);
      run_frame(1'b1, 1'b0, 1'b0);
      chk("t5_pulse_hdr_on", cexp_cnt - c0, 1);
      c0 = cexp_cnt;
      run_frame(1'b0, 1'b0, 1'b0);
      chk("t5_pulse_hdr_off", cexp_cnt - c0, 0);

      // 6: take_pic mid-line, then reset mid-frame
      do_reset();
      run_frame(1'b0, 1'b0, 1'b0);
      hdr_en = 1'b0;
      vsync = 1'b0; tick(); tick();
      for (int k = 0; k < 5; k++) send_byte(8'(8'h20 + k), k, 0, m_idx * FW);
      take_pic = 1'b1; data = 8'hAA; tick();
      tick(); href = 1'b0; tick(); vsync = 1'b1; tick(); tick();
      take_pic = 1'b0; tick();
      chk("t6_wr_addr_rearm", wr_addr, 4);
      chk("t6_frame_idx_hold", frame_idx, 1);
      seen.delete();
      run_frame(1'b0, 1'b0, 1'b0);
      if (seen.size() != 0) chk("t6_next_frame_addr", seen[0].addr, 4);
      else chk("t6_next_frame_strobes", seen.size(), 4);
      vsync = 1'b0; tick(); tick();
      for (int k = 0; k < 6; k++) send_byte(8'($urandom), k, 0, m_idx * FW);
      do_reset();

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         int nl, sel;
         sel = $urandom_range(0, 9);
         nl = (sel == 0) ? IMG_H - 1 : (sel == 1) ? IMG_H + 1 : IMG_H;
         line_len.delete();
         for (int l = 0; l < nl; l++)
            line_len.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(1, LB + 3) : LB);
         run_frame(1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) == 0));
      end

      tick(); tick();
      chk("pending_strobes", sq.size(), 0);
      chk("pending_frames", fq.size(), 0);
      chk("pending_exp", cq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
